// File: rtl/phase_encoder.sv
// Frame-driven phase encoder: each channel's output line inverts once per frame, at a
// programmable cycle offset from the frame start.
module phase_encoder #(
  parameter int unsigned PHASE_WIDTH = 11,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [ADDR_WIDTH-1:0]  cfg_addr,
  input  logic [CNT_WIDTH-1:0]   cfg_data,
  input  logic [CNT_WIDTH-1:0]   period,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [PHASE_WIDTH-1:0] data_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   per_q, per_d;
  logic [CNT_WIDTH-1:0]   dly_q [PHASE_WIDTH];
  logic [PHASE_WIDTH-1:0] data_q, data_d;
  logic [PHASE_WIDTH-1:0] toggle, dly_we;
  logic                   busy_q, done_q;
  logic                   start_ok, last_cycle;

  assign start_ok   = (state_q == StIdle) && start && (period != '0);
  assign last_cycle = (cnt_q == per_q - 1'b1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StRun;
          cnt_d   = '0;
          per_d   = period;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 1'b1;
        if (last_cycle) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Out-of-range addresses match no channel, so they write nothing.
  always_comb begin
    toggle = '0;
    dly_we = '0;
    for (int i = 0; i < PHASE_WIDTH; i++) begin
      toggle[i] = (state_q == StRun) && (cnt_q == dly_q[i]);
      dly_we[i] = cfg_we && (state_q == StIdle) && (cfg_addr == ADDR_WIDTH'(i));
    end
    data_d = data_q ^ toggle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      per_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < PHASE_WIDTH; i++) dly_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      data_q  <= data_d;
      busy_q  <= (state_d == StRun);
      done_q  <= (state_d == StDone);
      for (int i = 0; i < PHASE_WIDTH; i++) begin
        if (dly_we[i]) dly_q[i] <= cfg_data;
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign data_o = data_q;

endmodule

// File: tb/tb_phase_encoder.sv
// Scoreboard bench for phase_encoder: frames push expected results, a negedge monitor
// measures each frame (length, per-bit toggle offset, final data) and pops on done.
module tb_phase_encoder;
  localparam int PW = 11;
  localparam int CW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst, cfg_we, start;
  logic [AW-1:0] cfg_addr;
  logic [CW-1:0] cfg_data, period;
  logic          busy, done;
  logic [PW-1:0] data_o;

  typedef struct packed {
    logic [PW-1:0]      data;
    logic [7:0]         len;
    logic [PW-1:0][7:0] tog;   // edge offset from frame start, 'hFF = no toggle
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0, n_frames = 0, n_done = 0;

  always #5 clk = ~clk;

  phase_encoder dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .period   (period),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .data_o   (data_o)
  );

  task automatic chk(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, want, want);
    end
  endtask

  // Up to three channels get explicit toggle offsets; the rest use dflt.
  task automatic push_frame(input int d, input int len, input int dflt,
                            input int ba, input int ta, input int bb, input int tb2,
                            input int bc, input int tc);
    exp_t e;
    e.data = PW'(d);
    e.len  = 8'(len);
    for (int i = 0; i < PW; i++) e.tog[i] = 8'(dflt);
    if (ba >= 0) e.tog[ba] = 8'(ta);
    if (bb >= 0) e.tog[bb] = 8'(tb2);
    if (bc >= 0) e.tog[bc] = 8'(tc);
    exp_q.push_back(e);
    n_frames++;
  endtask

  // Monitor
  initial begin
    logic               in_frame;
    int                 rel;
    logic [PW-1:0]      prev_data;
    logic [PW-1:0][7:0] seen;
    exp_t               e;
    in_frame  = 1'b0;
    rel       = 0;
    prev_data = '0;
    seen      = '1;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 1'b0;
      end else begin
        if (busy && !in_frame) begin
          in_frame = 1'b1;
          rel      = 0;
          seen     = '1;
        end else if (in_frame) begin
          rel++;
        end
        if (in_frame) begin
          for (int i = 0; i < PW; i++) if (data_o[i] != prev_data[i]) seen[i] = 8'(rel);
        end
        if (done) begin
          n_done++;
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("frame_len", in_frame ? rel : -1, int'(e.len));
            chk("busy_at_done", int'(busy), 0);
            chk("data_at_done", int'(data_o), int'(e.data));
            for (int i = 0; i < PW; i++)
              chk($sformatf("toggle_edge_bit%0d", i), int'(seen[i]), int'(e.tog[i]));
          end
          in_frame = 1'b0;
        end
      end
      prev_data = data_o;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    cfg_we   = 1'b1;
    cfg_addr = AW'(a);
    cfg_data = CW'(d);
    cyc(1);
    cfg_we   = 1'b0;
  endtask

  task automatic go(input int p);
    period = CW'(p);
    start  = 1'b1;
    cyc(1);
    start  = 1'b0;
  endtask

  task automatic park();
    for (int i = 0; i < PW; i++) wr(i, 255);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((busy || done) && k < 200) begin
      cyc(1);
      k++;
    end
    chk({name, "_idle_timeout"}, int'(busy || done), 0);
  endtask

  initial begin
    int d0;
    // Reset overrides an active write and start.
    rst = 1'b1; cfg_we = 1'b1; cfg_addr = '0; cfg_data = 8'd7; period = 8'd5; start = 1'b1;
    cyc(2);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_data", int'(data_o), 0);
    rst = 1'b0; cfg_we = 1'b0; start = 1'b0;
    cyc(2);
    chk("post_rst_busy", int'(busy), 0);

    // Basic frame
    park();
    wr(0, 0); wr(3, 5); wr(10, 9);
    push_frame('h409, 10, 255, 0, 1, 3, 6, 10, 10);
    go(10);
    chk("busy_after_start", int'(busy), 1);
    wait_idle("basic");

    // Out-of-range delay; dly=per-1 toggles on the done edge
    do_reset(); park();
    wr(2, 12); wr(4, 11);
    push_frame('h010, 12, 255, 4, 12, -1, 0, -1, 0);
    go(12);
    wait_idle("oor");

    // Zero period is ignored
    go(0);
    for (int i = 0; i < 4; i++) begin
      chk("p0_busy", int'(busy), 0);
      chk("p0_done", int'(done), 0);
      cyc(1);
    end
    chk("p0_data", int'(data_o), 'h010);

    // Start and period changes during RUN/DONE are ignored, not queued
    push_frame('h010, 6, 255, -1, 0, -1, 0, -1, 0);
    go(6);
    start = 1'b1; period = 8'd3;
    cyc(7);
    start = 1'b0;
    wait_idle("restart");
    cyc(3);
    chk("no_queued_start", int'(busy), 0);

    // Write during RUN ignored
    do_reset(); park();
    wr(6, 0);
    push_frame('h040, 8, 255, 6, 1, -1, 0, -1, 0);
    go(8);
    wr(1, 3);
    wait_idle("run_wr_a");
    push_frame('h000, 8, 255, 6, 1, -1, 0, -1, 0);
    go(8);
    wait_idle("run_wr_b");

    // Out-of-range address ignored
    wr(13, 0);
    push_frame('h040, 8, 255, 6, 1, -1, 0, -1, 0);
    go(8);
    wait_idle("bad_addr");

    // Reset mid-frame aborts without done; delays return to 0
    do_reset(); park();
    wr(0, 0); wr(7, 10);
    go(20);
    cyc(3);
    d0 = n_done;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("abort_data", int'(data_o), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    cyc(25);
    chk("abort_no_done", n_done - d0, 0);
    push_frame('h7FF, 5, 1, -1, 0, -1, 0, -1, 0);
    go(5);
    wait_idle("after_abort");

    // Coincident write+start uses new value; two frames toggle up then down
    do_reset(); park();
    push_frame('h020, 4, 255, 5, 3, -1, 0, -1, 0);
    cfg_we = 1'b1; cfg_addr = 4'd5; cfg_data = 8'd2; period = 8'd4; start = 1'b1;
    cyc(1);
    cfg_we = 1'b0; start = 1'b0;
    wait_idle("frame1");
    push_frame('h000, 4, 255, 5, 3, -1, 0, -1, 0);
    go(4);
    wait_idle("frame2");

    cyc(3);
    chk("queue_empty", exp_q.size(), 0);
    chk("done_count", n_done, n_frames);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/phase_encoder.md
PHASE_ENCODER -- requirements
Module: phase_encoder

Interface
REQ-001 The module SHALL have parameter PHASE_WIDTH, default 11, giving the number of phase channels.
REQ-002 The module SHALL have parameter CNT_WIDTH, default 8, giving the width of the frame counter, delay codes and period.
REQ-003 The module SHALL have parameter ADDR_WIDTH, default 4, giving the channel-select width, with 2**ADDR_WIDTH >= PHASE_WIDTH.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port cfg_we, input, 1 bit: delay-register write strobe.
REQ-007 The module SHALL have port cfg_addr, input, ADDR_WIDTH bits: channel index for the write.
REQ-008 The module SHALL have port cfg_data, input, CNT_WIDTH bits: delay code to write.
REQ-009 The module SHALL have port period, input, CNT_WIDTH bits: frame length in cycles, sampled at start.
REQ-010 The module SHALL have port start, input, 1 bit: frame request, a one-cycle level that is sampled each edge.
REQ-011 The module SHALL have port busy, output, 1 bit: high while a frame runs.
REQ-012 The module SHALL have port done, output, 1 bit: a one-cycle pulse at frame end.
REQ-013 The module SHALL have port data_o, output, PHASE_WIDTH bits: per-channel phase-encoded toggle lines, one register per bit, feeding the per-bit edge-detect readout.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE, and SHALL leave reset in IDLE.
REQ-015 Delay registers dly[0..PHASE_WIDTH-1] SHALL follow these write rules:
- In IDLE, cfg_we=1 writes cfg_data into dly[cfg_addr] at the edge.
- In RUN or DONE, writes SHALL be ignored.
- Writes with cfg_addr >= PHASE_WIDTH SHALL be ignored.
REQ-016 In IDLE, start=1 with period!=0 SHALL, at the same edge:
- capture period into per_q;
- clear counter cnt to 0;
- enter RUN.
REQ-017 In IDLE, start=1 with period==0 SHALL be ignored: no state change and no toggles.
REQ-018 If cfg_we and an accepted start coincide in IDLE, the write SHALL take effect, and the frame SHALL use the newly written value.
REQ-019 In RUN, cnt SHALL increment by 1 per cycle, starting at 0.
REQ-020 When cnt == per_q-1, the FSM SHALL enter DONE at the next edge.
REQ-021 In RUN, when cnt == dly[i], data_o[i] SHALL invert at the next edge, so each channel toggles at most once per frame.
REQ-022 A channel with dly[i] >= per_q SHALL NOT toggle in that frame.
REQ-023 Timing: with start accepted at edge t0, data_o[i] toggles at edge t0+1+dly[i], and DONE is entered at edge t0+per_q.
REQ-024 busy SHALL be 1 exactly while in RUN (registered): high from edge t0 to edge t0+per_q.
REQ-025 done SHALL be 1 exactly while in DONE, for one cycle; the FSM SHALL return to IDLE at the next edge, t0+per_q+1.
REQ-026 start asserted in RUN or DONE SHALL be ignored and SHALL NOT be queued; back-to-back frames need a start in IDLE, so the minimum frame spacing is per_q+2 cycles.
REQ-027 data_o SHALL hold its level between frames; it is not cleared at frame end.
REQ-028 A change on period during RUN SHALL NOT affect the running frame.
REQ-029 Width rules:
- cnt is CNT_WIDTH bits and never wraps, because per_q <= 2**CNT_WIDTH-1.
- Delay comparisons are unsigned equality.

Reset
REQ-030 rst=1 at an edge SHALL set the following, overriding all other inputs including cfg_we and start:
- state=IDLE;
- cnt=0 and per_q=0;
- all dly=0;
- data_o=0;
- busy=0 and done=0.
REQ-031 rst asserted mid-frame SHALL abort the frame with no done pulse; outputs take their reset values at that edge.

Verification
REQ-032 The bench SHALL cover the basic frame:
- Stimulus: write dly[0]=0, dly[3]=5, dly[10]=9; period=10; start at edge t0.
- Response: data_o[0] toggles at t0+1, bit3 at t0+6, bit10 at t0+10; busy high t0..t0+10; done=1 for the cycle after t0+10.
REQ-033 The bench SHALL cover out-of-range delay: dly[2]=12 with period=12 -> data_o[2] never toggles, and done is asserted at t0+12.
REQ-034 The bench SHALL cover ignored inputs:
- start with period=0 -> stays IDLE, busy=0, done=0.
- start during RUN -> no effect, exactly one done pulse.
REQ-035 The bench SHALL cover write rules:
- cfg_we during RUN with addr=1, data=3 -> dly[1] unchanged in the next frame.
- cfg_addr=13 in IDLE -> no register changes.
REQ-036 The bench SHALL cover reset mid-frame: rst at t0+4 of a period=20 frame -> data_o=0, busy=0, no done, and the next start behaves as after power-up.
REQ-037 The bench SHALL cover two consecutive frames with dly[5]=2: data_o[5] goes 0->1 in frame 1 and 1->0 in frame 2.
